// File: rtl/oled_spi_engine_if.sv
// Write-side bus of the OLED SPI engine: {dc,byte} push port and FIFO status.
interface oled_spi_engine_if;
    logic       wr_en;
    logic       wr_dc;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       ovf;

    modport master (
        output wr_en, wr_dc, wr_data,
        input  full, empty, ovf
    );

    modport slave (
        input  wr_en, wr_dc, wr_data,
        output full, empty, ovf
    );
endinterface

// File: rtl/oled_spi_engine.sv
// 4-wire SPI transmit engine for SSD1306-class OLEDs: panel reset, {dc,byte} FIFO, MSB-first shifter.
// Define OLED_SPI_BURST_EN to keep csn low across back-to-back queued bytes.
module oled_spi_engine #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int RST_CYCLES = 50000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    oled_spi_engine_if.slave wr,
    output logic             busy,
    output logic             init_done,
    output logic             oled_rst,
    output logic             oled_csn,
    output logic             oled_dcn,
    output logic             oled_clk,
    output logic             oled_dat
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (RST_CYCLES > CLK_DIV) ? RST_CYCLES : CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT1     = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR1     = AW'(1);

    typedef enum logic [2:0] {
        RST_LO,
        RST_WAIT,
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    sh, sh_nxt;
    logic          rst_nxt, csn_nxt, dcn_nxt, clk_nxt, dat_nxt;
    logic          busy_nxt, done_nxt;
    logic          start;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          full_q, empty_q, ovf_q;
    logic          push, pop;
    logic [8:0]    head;

    assign wr.full  = full_q;
    assign wr.empty = empty_q;
    assign wr.ovf   = ovf_q;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push = wr.wr_en && !full_q;
    assign head = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CNT1;
            2'b01:   count_nxt = count - CNT1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr.wr_dc, wr.wr_data};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR1;
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == DEPTH);
            empty_q <= (count_nxt == '0);
            if (wr.wr_en && full_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        sh_nxt      = sh;
        rst_nxt     = oled_rst;
        csn_nxt     = oled_csn;
        dcn_nxt     = oled_dcn;
        clk_nxt     = oled_clk;
        dat_nxt     = oled_dat;
        busy_nxt    = busy;
        done_nxt    = init_done;
        start       = 1'b0;
        pop         = 1'b0;

        unique case (state)
            RST_LO: begin
                cnt_nxt = cnt + CNT_ONE;
                if (cnt == RST_LAST) begin
                    cnt_nxt   = '0;
                    rst_nxt   = 1'b1;
                    state_nxt = RST_WAIT;
                end
            end
            RST_WAIT: begin
                cnt_nxt = cnt + CNT_ONE;
                if (cnt == RST_LAST) begin
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                start = !empty_q;
            end
            LOAD: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                state_nxt   = SHIFT;
            end
            SHIFT: begin
                cnt_nxt = cnt + CNT_ONE;
                if (cnt == DIV_LAST) begin
                    cnt_nxt = '0;
                    if (!oled_clk) begin
                        clk_nxt = 1'b1;
                    end else if (bit_idx == 3'd7) begin
                        clk_nxt  = 1'b0;
                        busy_nxt = 1'b0;
`ifdef OLED_SPI_BURST_EN
                        if (!empty_q) begin
                            start = 1'b1;
                        end else begin
                            csn_nxt   = 1'b1;
                            state_nxt = GAP;
                        end
`else
                        csn_nxt   = 1'b1;
                        state_nxt = GAP;
`endif
                    end else begin
                        // Data only moves on the falling edge so the panel sees it settled.
                        clk_nxt     = 1'b0;
                        dat_nxt     = sh[6];
                        sh_nxt      = {sh[6:0], 1'b0};
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            GAP: begin
                cnt_nxt = cnt + CNT_ONE;
                if (cnt == DIV_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    start     = !empty_q;
                end
            end
            default: begin
                state_nxt = RST_LO;
            end
        endcase

        // Popping registers the LOAD outputs so they are valid for the whole LOAD cycle.
        if (start) begin
            pop       = 1'b1;
            state_nxt = LOAD;
            csn_nxt   = 1'b0;
            dcn_nxt   = head[8];
            sh_nxt    = head[7:0];
            dat_nxt   = head[7];
            clk_nxt   = 1'b0;
            busy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= RST_LO;
            cnt       <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            oled_rst  <= 1'b0;
            oled_csn  <= 1'b1;
            oled_dcn  <= 1'b0;
            oled_clk  <= 1'b0;
            oled_dat  <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            sh        <= sh_nxt;
            oled_rst  <= rst_nxt;
            oled_csn  <= csn_nxt;
            oled_dcn  <= dcn_nxt;
            oled_clk  <= clk_nxt;
            oled_dat  <= dat_nxt;
            busy      <= busy_nxt;
            init_done <= done_nxt;
        end
    end
endmodule

// File: tb/tb_oled_spi_engine.sv
// Directed bench for oled_spi_engine: reset sequence, FIFO limits, SPI framing, mid-byte reset.
module tb_oled_spi_engine;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int RST_CYCLES = 10;
`ifdef OLED_SPI_BURST_EN
    localparam int EXP_WIN  = 1;
    localparam int EXP_RISE = 21 + 4 * 33;
`else
    localparam int EXP_WIN  = 4;
    localparam int EXP_RISE = 54;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic busy, init_done, oled_rst, oled_csn, oled_dcn, oled_clk, oled_dat;

    oled_spi_engine_if wr_bus();

    oled_spi_engine #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .wr       (wr_bus),
        .busy     (busy),
        .init_done(init_done),
        .oled_rst (oled_rst),
        .oled_csn (oled_csn),
        .oled_dcn (oled_dcn),
        .oled_clk (oled_clk),
        .oled_dat (oled_dat)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [8:0] rx_q[$];
    logic [7:0] rx_sh    = 8'h00;
    logic       rx_dc    = 1'b0;
    int         nb       = 0;
    int         unstable = 0;
    int         rises    = 0;

    // Panel model: samples on every rising SPI clock while selected.
    always @(posedge oled_clk) begin
        rises++;
        if (!oled_csn) begin
            rx_sh = {rx_sh[6:0], oled_dat};
            if (nb == 0) rx_dc = oled_dcn;
            else if (oled_dcn != rx_dc) unstable++;
            nb++;
            if (nb == 8) begin
                rx_q.push_back({rx_dc, rx_sh});
                nb = 0;
            end
        end
    end

    logic [8:0] vec[5] = '{9'h0AE, 9'h1A5, 9'h03C, 9'h181, 9'h1FF};

    initial begin
        int rst_k, done_k, pre_act, bad_gap, t, r0, nrx;
        int falls[$];
        int csn_up[$];
        int clkr[$];
        logic pc, pk;
        rst_k   = -1;
        done_k  = -1;
        pre_act = 0;
        bad_gap = 0;
        wr_bus.wr_en   = 1'b0;
        wr_bus.wr_dc   = 1'b0;
        wr_bus.wr_data = 8'h00;

        #12;
        check("rst_oled_rst", oled_rst, 0);
        check("rst_csn", oled_csn, 1);
        check("rst_dcn", oled_dcn, 0);
        check("rst_clk", oled_clk, 0);
        check("rst_dat", oled_dat, 0);
        check("rst_full", wr_bus.full, 0);
        check("rst_empty", wr_bus.empty, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", wr_bus.ovf, 0);
        check("rst_done", init_done, 0);

        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        wr_bus.wr_en = 1'b1;
        {wr_bus.wr_dc, wr_bus.wr_data} = vec[0];
        pc = oled_csn;
        pk = oled_clk;

        for (int k = 1; k <= 200; k++) begin
            @(posedge sys_clk);
            #1;
            if (oled_rst && rst_k < 0) rst_k = k;
            if (init_done && done_k < 0) done_k = k;
            if (!init_done && (!oled_csn || oled_clk || busy)) pre_act++;
            if (pc && !oled_csn) falls.push_back(k);
            if (!pc && oled_csn) csn_up.push_back(k);
            if (!pk && oled_clk) clkr.push_back(k);
            pc = oled_csn;
            pk = oled_clk;
            if (k == 3) check("full_at3", wr_bus.full, 0);
            if (k == 4) begin
                check("full_at4", wr_bus.full, 1);
                check("ovf_at4", wr_bus.ovf, 0);
            end
            if (k == 5) check("ovf_at5", wr_bus.ovf, 1);
            if (k < 5) {wr_bus.wr_dc, wr_bus.wr_data} = vec[k];
            else wr_bus.wr_en = 1'b0;
        end

        check("rst_rise_cycle", rst_k, RST_CYCLES);
        check("init_done_cycle", done_k, 2 * RST_CYCLES);
        check("quiet_before_init", pre_act, 0);
        check("csn_windows", falls.size(), EXP_WIN);
        check("first_csn_fall", falls.size() > 0 ? falls[0] : -1, 21);
        check("first_csn_rise", csn_up.size() > 0 ? csn_up[0] : -1, EXP_RISE);
`ifndef OLED_SPI_BURST_EN
        check("second_csn_fall", falls.size() > 1 ? falls[1] : -1, 56);
`endif
        check("clk_rises_total", clkr.size(), 32);
        check("first_clk_rise", clkr.size() > 0 ? clkr[0] : -1, 24);
        check("eighth_clk_rise", clkr.size() > 7 ? clkr[7] : -1, 52);
        for (int i = 1; i < 8 && i < clkr.size(); i++)
            if (clkr[i] - clkr[i-1] != 2 * CLK_DIV) bad_gap++;
        check("clk_rise_spacing", bad_gap, 0);
        check("rx_count", rx_q.size(), 4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++)
            check($sformatf("rx_byte%0d", i), rx_q[i], vec[i]);
        check("dcn_stable", unstable, 0);
        check("empty_after", wr_bus.empty, 1);
        check("busy_after", busy, 0);

        wr_bus.wr_en = 1'b1;
        {wr_bus.wr_dc, wr_bus.wr_data} = 9'h155;
        @(posedge sys_clk);
        #1;
        {wr_bus.wr_dc, wr_bus.wr_data} = 9'h166;
        @(posedge sys_clk);
        #1;
        wr_bus.wr_en = 1'b0;
        t = 0;
        while (nb < 3 && t < 100) begin
            @(posedge sys_clk);
            #1;
            t++;
        end
        check("bit3_reached", t < 100, 1);

        #2;
        sys_rst_n = 1'b0;
        #1;
        check("mid_oled_rst", oled_rst, 0);
        check("mid_csn", oled_csn, 1);
        check("mid_clk", oled_clk, 0);
        check("mid_dat", oled_dat, 0);
        check("mid_busy", busy, 0);
        check("mid_empty", wr_bus.empty, 1);
        check("mid_done", init_done, 0);
        r0  = rises;
        nrx = rx_q.size();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        nb = 0;
        repeat (5) @(posedge sys_clk);
        #1;
        check("restart_rst_low", oled_rst, 0);
        t = 0;
        while (!init_done && t < 60) begin
            @(posedge sys_clk);
            #1;
            t++;
        end
        check("restart_init_done", init_done, 1);
        repeat (60) @(posedge sys_clk);
        #1;
        check("flush_no_clk", rises, r0);
        check("flush_no_rx", rx_q.size(), nrx);
        check("flush_empty", wr_bus.empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
